// File: rtl/ps2_kbd_tx.sv
// ps2_kbd_tx: device-side PS/2 transmitter that emulates a keyboard.
// It queues scancode bytes in a FIFO and sends each one as an 11-bit frame
// on ps2_clk/ps2_data.
//
// Ports:
//   clk, rst          system clock and asynchronous active-low reset
//   in_data/in_valid  byte to queue; it is accepted when in_ready is high
//   in_ready          FIFO not full
//   ps2_clk/ps2_data  PS/2 lines to the receiver; both idle high
//   busy              frame engine not idle
//   frame_done        one-cycle pulse as ps2_clk returns high after the stop bit
//   fifo_count        queued bytes, not counting the frame in flight
//
// Optional: defining PS2_ERR_INJ_EN adds the inj_parity_err input.
// When inj_parity_err is high during LOAD, that frame goes out with even parity.
//
// ps2_clk, ps2_data, busy and frame_done are registered from the FSM state.
// They therefore trail the state by one cycle, and the start bit appears on
// ps2_data three cycles after the push into an idle, empty block.
module ps2_kbd_tx #(
  parameter int CLK_HALF   = 50,
  parameter int IDLE_GAP   = 200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
`ifdef PS2_ERR_INJ_EN
  input  logic                          inj_parity_err,
`endif
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          ps2_clk,
  output logic                          ps2_data,
  output logic                          busy,
  output logic                          frame_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int TMAX = IDLE_GAP > CLK_HALF ? IDLE_GAP : CLK_HALF;
  localparam int TW   = $clog2(TMAX) + 1;
  localparam logic [CW-1:0] FULL     = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] HALF_END = TW'(CLK_HALF - 1);
  localparam logic [TW-1:0] GAP_END  = TW'(IDLE_GAP - 1);
  typedef enum logic [2:0] {IDLE, LOAD, BIT_HI, BIT_LO, GAP} state_t;
  state_t state, state_nx;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [10:0] sh;
  logic [3:0] idx;
  logic [TW-1:0] tmr;
  logic push, pop, tmr_end, par;
  assign in_ready = fifo_count != FULL;
  assign push = in_valid && in_ready;
  assign pop = state == LOAD;
  assign tmr_end = tmr == (state == GAP ? GAP_END : HALF_END);
`ifdef PS2_ERR_INJ_EN
  assign par = ~^mem[rd_ptr] ^ inj_parity_err;
`else
  assign par = ~^mem[rd_ptr];
`endif
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= in_data;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE   ? (fifo_count != '0 ? LOAD : IDLE) :
               state == LOAD   ? BIT_HI :
               state == BIT_HI ? (tmr_end ? BIT_LO : BIT_HI) :
               state == BIT_LO ? (tmr_end ? (idx == 4'd10 ? GAP : BIT_HI) : BIT_LO) :
                                 (tmr_end ? IDLE : GAP);
  end
  // The shift register holds the frame LSB-first. The head bit is the one on the wire.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tmr <= '0;
      idx <= '0;
      sh <= '1;
    end else begin
      tmr <= state_nx != state ? '0 : tmr + 1'b1;
      if (state == LOAD) begin
        sh <= {1'b1, par, mem[rd_ptr], 1'b0};
        idx <= '0;
      end else if (state == BIT_LO && tmr_end) begin
        sh <= {1'b1, sh[10:1]};
        idx <= idx + 1'b1;
      end
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ps2_clk <= 1'b1;
      ps2_data <= 1'b1;
      busy <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      ps2_clk <= state != BIT_LO;
      ps2_data <= (state == BIT_HI || state == BIT_LO) ? sh[0] : 1'b1;
      busy <= state != IDLE;
      frame_done <= state == GAP && tmr == '0;
    end
endmodule
